// File: rtl/image_memory_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : image_memory_loader_if
// Purpose  : Pixel stream (valid/ready) and registered read port bundle for
//            the image memory loader.
// Revision : 1.0 - initial release
// ============================================================================
interface image_memory_loader_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output in_valid,
        output in_data,
        output rd_addr,
        input  in_ready,
        input  rd_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  rd_addr,
        output in_ready,
        output rd_data
    );
endinterface
`default_nettype wire

// File: rtl/image_memory_loader.sv
`default_nettype none
// ============================================================================
// Module   : image_memory_loader
// Purpose  : Input image buffer: clears on enable_memory, loads DEPTH words
//            from a valid/ready stream, serves a registered read port.
//            Optional macro MEM_ZERO_FILL_EN zero-fills storage on every clear.
// Revision : 1.0 - initial release
// ============================================================================
module image_memory_loader #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 784,
    parameter int ADDR_W = 10
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              enable_memory,
    image_memory_loader_if.slave   bus,
    output logic [ADDR_W:0]        word_count,
    output logic                   load_done
);

    localparam logic [ADDR_W:0] c_depth = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] c_last  = c_depth - 1'b1;

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_LOAD  = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W:0]     r_word_count;
    logic [DATA_W-1:0]   r_rd_data;
    logic [DATA_W-1:0]   r_mem [0:DEPTH-1];

    logic                w_commit;
    logic                w_clear_ok;
    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [DATA_W-1:0]   w_mem_wdata;
    logic                w_rd_in_range;

    // A clear in the same cycle as a handshake swallows the word.
    assign w_commit      = bus.in_valid && (r_state == S_LOAD) && !enable_memory;
    assign w_rd_in_range = ({1'b0, bus.rd_addr} < c_depth);

`ifdef MEM_ZERO_FILL_EN
    logic [ADDR_W-1:0]   r_sweep_addr;
    logic                r_sweep_done;
    logic                r_en_prev;
    logic                w_restart;
    logic                w_sweep_we;
    logic                w_sweep_last;

    // A sweep restarts on entry into CLEAR or on a fresh clear pulse while in CLEAR.
    assign w_restart    = enable_memory && ((r_state != S_CLEAR) || !r_en_prev);
    assign w_sweep_we   = (r_state == S_CLEAR) && !r_sweep_done && !w_restart;
    assign w_sweep_last = w_sweep_we && (r_sweep_addr == c_last[ADDR_W-1:0]);
    assign w_clear_ok   = r_sweep_done || w_sweep_last;

    assign w_mem_we     = w_commit || w_sweep_we;
    assign w_mem_addr   = w_sweep_we ? r_sweep_addr : r_word_count[ADDR_W-1:0];
    assign w_mem_wdata  = w_sweep_we ? '0 : bus.in_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sweep_addr <= '0;
            r_sweep_done <= 1'b0;
            r_en_prev    <= 1'b0;
        end else begin
            r_en_prev <= enable_memory;
            if (w_restart) begin
                r_sweep_addr <= '0;
                r_sweep_done <= 1'b0;
            end else if (w_sweep_we) begin
                r_sweep_addr <= r_sweep_addr + 1'b1;
                if (w_sweep_last) begin
                    r_sweep_done <= 1'b1;
                end
            end
        end
    end
`else
    assign w_clear_ok   = 1'b1;
    assign w_mem_we     = w_commit;
    assign w_mem_addr   = r_word_count[ADDR_W-1:0];
    assign w_mem_wdata  = bus.in_data;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (enable_memory) begin
            w_state_next = S_CLEAR;
        end else begin
            case (r_state)
                S_CLEAR: if (w_clear_ok) w_state_next = S_LOAD;
                S_LOAD:  if (w_commit && (r_word_count == c_last)) w_state_next = S_FULL;
                S_FULL:  w_state_next = S_FULL;
                default: w_state_next = S_CLEAR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_word_count <= '0;
        end else if (enable_memory) begin
            r_word_count <= '0;
        end else if (w_commit) begin
            r_word_count <= r_word_count + 1'b1;
        end
    end

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // Read-first: the nonblocking write above lands after this sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_data <= '0;
        end else if (w_rd_in_range) begin
            r_rd_data <= r_mem[bus.rd_addr];
        end else begin
            r_rd_data <= '0;
        end
    end

    assign bus.in_ready = (r_state == S_LOAD);
    assign bus.rd_data  = r_rd_data;
    assign load_done    = (r_state == S_FULL);
    assign word_count   = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_image_memory_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_image_memory_loader
// Purpose  : Directed self-checking bench for image_memory_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_image_memory_loader;

    localparam int DEPTH = 784;
`ifdef MEM_ZERO_FILL_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        enable_memory;
    logic [10:0] word_count;
    logic        load_done;

    int errors = 0;
    int checks = 0;

    image_memory_loader_if #(.DATA_W(8), .ADDR_W(10)) bus ();

    image_memory_loader #(.DATA_W(8), .DEPTH(DEPTH), .ADDR_W(10)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable_memory (enable_memory),
        .bus           (bus.slave),
        .word_count    (word_count),
        .load_done     (load_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Streams words until stop_at have been handed over; counts anomalies for the caller.
    task automatic load_image(input int stride, input logic [7:0] x, input bit all_ff,
                              input logic [7:0] old_x, input int stop_at,
                              output int ready_cycles, output int wc_bad,
                              output int rf_bad, output bit timeout);
        int k; int cyc; int phase; bit pend; logic [7:0] pexp; logic [10:0] k11;
        k = 0; cyc = 0; phase = 0; pend = 0; pexp = '0;
        ready_cycles = 0; wc_bad = 0; rf_bad = 0; timeout = 0;
        enable_memory = 1'b0;
        while (k < stop_at && !timeout) begin
            @(negedge clk);
            cyc++;
            if (pend && bus.rd_data !== pexp) rf_bad++;
            pend = 0;
            k11 = k[10:0];
            if (word_count !== k11) wc_bad++;
            bus.in_valid = 1'b0;
            if (bus.in_ready) begin
                ready_cycles++;
                if (phase == 0) begin
                    bus.in_valid = 1'b1;
                    bus.in_data  = all_ff ? 8'hFF : (k[7:0] ^ x);
                    bus.rd_addr  = k[9:0];
                    pexp = ZF ? 8'h00 : (k[7:0] ^ old_x);
                    pend = 1;
                    k++;
                end
                phase = (phase + 1) % stride;
            end
            if (cyc > 5000) timeout = 1;
        end
        @(negedge clk);
        if (pend && bus.rd_data !== pexp) rf_bad++;
        bus.in_valid = 1'b0;
    endtask

    task automatic verify_image(input logic [7:0] x, input logic [7:0] m, output int bad);
        logic [7:0] e;
        bad = 0;
        for (int i = 0; i <= DEPTH; i++) begin
            @(negedge clk);
            if (i > 0) begin
                e = (8'(i - 1) ^ x) & m;
                if (bus.rd_data !== e) bad++;
            end
            if (i < DEPTH) bus.rd_addr = 10'(i);
        end
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        enable_memory = 1'b1;
        @(negedge clk);
        enable_memory = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL reset_load_done: got %b want 0", load_done); end
        checks++; if (word_count !== 11'd0) begin errors++; $display("FAIL reset_word_count: got %0d want 0", word_count); end
        checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h want 00", bus.rd_data); end
        repeat (3) @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0 || load_done !== 1'b0) begin errors++; $display("FAIL reset_hold: got ready=%b done=%b want 0 0", bus.in_ready, load_done); end
    endtask

    task automatic test_back_to_back();
        int rc, wb, rb, bad; bit to;
        rst = 1'b1;
        load_image(1, 8'h00, 1'b0, 8'h00, DEPTH, rc, wb, rb, to);
        checks++; if (to) begin errors++; $display("FAIL b2b_timeout: got timeout want none"); end
        checks++; if (rc != DEPTH) begin errors++; $display("FAIL b2b_ready_cycles: got %0d want %0d", rc, DEPTH); end
        checks++; if (wb != 0) begin errors++; $display("FAIL b2b_word_count_track: got %0d bad want 0", wb); end
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL b2b_load_done: got %b want 1", load_done); end
        checks++; if (word_count !== 11'd784) begin errors++; $display("FAIL b2b_word_count: got %0d want 784", word_count); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready_full: got %b want 0", bus.in_ready); end
        bus.rd_addr = 10'd300;
        @(negedge clk);
        checks++; if (bus.rd_data !== 8'h2C) begin errors++; $display("FAIL b2b_read300: got %h want 2c", bus.rd_data); end
        verify_image(8'h00, 8'hFF, bad);
        checks++; if (bad != 0) begin errors++; $display("FAIL b2b_contents: got %0d bad words want 0", bad); end
    endtask

    task automatic test_full_hold();
        int bad;
        bad = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hEE;
        repeat (8) begin
            @(negedge clk);
            if (word_count !== 11'd784 || bus.in_ready !== 1'b0 || load_done !== 1'b1) bad++;
        end
        bus.in_valid = 1'b0;
        checks++; if (bad != 0) begin errors++; $display("FAIL full_hold: got %0d bad cycles want 0", bad); end
        bus.rd_addr = 10'd783;
        @(negedge clk);
        checks++; if (bus.rd_data !== 8'h0F) begin errors++; $display("FAIL full_read783: got %h want 0f", bus.rd_data); end
        bus.rd_addr = 10'd800;
        @(negedge clk);
        checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL oob_read800: got %h want 00", bus.rd_data); end
        bus.rd_addr = 10'd1023;
        @(negedge clk);
        checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL oob_read1023: got %h want 00", bus.rd_data); end
    endtask

    task automatic test_sparse();
        int rc, wb, rb, bad; bit to;
        pulse_clear();
        load_image(3, 8'h33, 1'b0, 8'h00, DEPTH, rc, wb, rb, to);
        checks++; if (to) begin errors++; $display("FAIL sparse_timeout: got timeout want none"); end
        checks++; if (wb != 0) begin errors++; $display("FAIL sparse_word_count_track: got %0d bad want 0", wb); end
        checks++; if (rb != 0) begin errors++; $display("FAIL sparse_read_first: got %0d bad want 0", rb); end
        checks++; if (load_done !== 1'b1 || word_count !== 11'd784) begin errors++; $display("FAIL sparse_done: got done=%b cnt=%0d want 1 784", load_done, word_count); end
        verify_image(8'h33, 8'hFF, bad);
        checks++; if (bad != 0) begin errors++; $display("FAIL sparse_contents: got %0d bad words want 0", bad); end
    endtask

    task automatic test_clear_abort();
        int rc, wb, rb, bad; bit to;
        pulse_clear();
        load_image(1, 8'h5A, 1'b0, 8'h33, 400, rc, wb, rb, to);
        checks++; if (word_count !== 11'd400) begin errors++; $display("FAIL abort_pre_count: got %0d want 400", word_count); end
        enable_memory = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'hA5;
        @(negedge clk);
        checks++; if (word_count !== 11'd0) begin errors++; $display("FAIL abort_word_count: got %0d want 0", word_count); end
        checks++; if (bus.in_ready !== 1'b0 || load_done !== 1'b0) begin errors++; $display("FAIL abort_flags: got ready=%b done=%b want 0 0", bus.in_ready, load_done); end
        bus.in_valid  = 1'b0;
        enable_memory = 1'b0;
`ifndef MEM_ZERO_FILL_EN
        bus.rd_addr = 10'd400;
        @(negedge clk);
        checks++; if (bus.rd_data !== 8'hA3) begin errors++; $display("FAIL abort_discard400: got %h want a3", bus.rd_data); end
        bus.rd_addr = 10'd399;
        @(negedge clk);
        checks++; if (bus.rd_data !== 8'hD5) begin errors++; $display("FAIL abort_kept399: got %h want d5", bus.rd_data); end
`endif
        load_image(1, 8'hC3, 1'b0, 8'h00, DEPTH, rc, wb, rb, to);
        checks++; if (to || load_done !== 1'b1 || word_count !== 11'd784) begin errors++; $display("FAIL abort_reload: got to=%b done=%b cnt=%0d want 0 1 784", to, load_done, word_count); end
        verify_image(8'hC3, 8'hFF, bad);
        checks++; if (bad != 0) begin errors++; $display("FAIL abort_contents: got %0d bad words want 0", bad); end
    endtask

    task automatic test_async_reset();
        int rc, wb, rb, bad; bit to;
        pulse_clear();
        load_image(1, 8'h11, 1'b0, 8'h00, 500, rc, wb, rb, to);
        bus.rd_addr = 10'd1;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1 || bus.rd_data !== 8'h10) begin errors++; $display("FAIL arst_pre: got ready=%b data=%h want 1 10", bus.in_ready, bus.rd_data); end
        #2 rst = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL arst_in_ready: got %b want 0", bus.in_ready); end
        checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL arst_rd_data: got %h want 00", bus.rd_data); end
        checks++; if (word_count !== 11'd0 || load_done !== 1'b0) begin errors++; $display("FAIL arst_count_done: got cnt=%0d done=%b want 0 0", word_count, load_done); end
        @(negedge clk);
        rst = 1'b1;
        load_image(1, 8'h77, 1'b0, 8'h00, DEPTH, rc, wb, rb, to);
        checks++; if (to || wb != 0 || load_done !== 1'b1 || word_count !== 11'd784) begin errors++; $display("FAIL arst_reload: got to=%b wb=%0d done=%b cnt=%0d want 0 0 1 784", to, wb, load_done, word_count); end
        verify_image(8'h77, 8'hFF, bad);
        checks++; if (bad != 0) begin errors++; $display("FAIL arst_contents: got %0d bad words want 0", bad); end
    endtask

`ifdef MEM_ZERO_FILL_EN
    task automatic test_zero_fill();
        int rc, wb, rb, bad, n; bit to;
        pulse_clear();
        load_image(1, 8'h00, 1'b1, 8'h00, DEPTH, rc, wb, rb, to);
        checks++; if (to || load_done !== 1'b1) begin errors++; $display("FAIL zf_load: got to=%b done=%b want 0 1", to, load_done); end
        @(negedge clk);
        enable_memory = 1'b1;
        @(negedge clk);
        enable_memory = 1'b0;
        n = 0;
        while (!bus.in_ready && n < 3000) begin
            n++;
            @(negedge clk);
        end
        checks++; if (n != DEPTH) begin errors++; $display("FAIL zf_dwell: got %0d cycles want %0d", n, DEPTH); end
        verify_image(8'h00, 8'h00, bad);
        checks++; if (bad != 0) begin errors++; $display("FAIL zf_contents: got %0d nonzero words want 0", bad); end
    endtask
`endif

    initial begin
        rst           = 1'b1;
        enable_memory = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.rd_addr   = 10'd0;
        test_reset();
        test_back_to_back();
        test_full_hold();
        test_sparse();
        test_clear_abort();
        test_async_reset();
`ifdef MEM_ZERO_FILL_EN
        test_zero_fill();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/image_memory_loader.md
# image_memory_loader

Memory-side responder to the phase controller's `enable_memory` line. It holds the input image buffer: it clears while `enable_memory` is 1 and accepts a valid/ready pixel stream while `enable_memory` is 0. It raises `load_done` once `DEPTH` words are stored. It also serves a registered read port to the computation module.

## Interface
- `DATA_W`, 8: pixel word width.
- `DEPTH`, 784: words per image (28x28).
- `ADDR_W`, 10: address width; must satisfy 2^ADDR_W >= DEPTH.
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `enable_memory`  in  1  controller phase line; 1 = clear/hold, 0 = load.
- `in_valid`  in  1  source has a word on `in_data`.
- `in_data`  in  DATA_W  pixel word.
- `in_ready`  out  1  loader accepts a word this cycle.
- `rd_addr`  in  ADDR_W  read address from the computation module.
- `rd_data`  out  DATA_W  registered read data.
- `word_count`  out  ADDR_W+1  number of words stored since the last clear.
- `load_done`  out  1  high while the buffer holds a full image.

## Operation
- States:
  - CLEAR (`in_ready`=0, `word_count` forced to 0).
  - LOAD (`in_ready`=1).
  - FULL (`in_ready`=0, `load_done`=1).
- Transfer occurs on a rising edge when `in_valid` and `in_ready` are both 1. The transfer writes `mem[word_count]` and increments `word_count`.
- CLEAR -> LOAD when the sampled `enable_memory` is 0 (and, with the macro, the zero-fill sweep is complete).
- LOAD -> FULL on the edge that accepts word `DEPTH`-1. On that edge `word_count` becomes `DEPTH`, so no extra word is ever accepted.
- Any state -> CLEAR on an edge where `enable_memory` is 1. This takes priority over a transfer in the same cycle: the word is consumed from the source but discarded, and `word_count` goes to 0.
- FULL holds while `enable_memory` is 0. A new image requires a clear (`enable_memory` pulsed to 1).
- `in_valid` while `in_ready`=0: ignored; the source must hold its data.
- `in_valid` deasserting mid-image: LOAD waits indefinitely; there is no timeout.
- Reads:
  - `rd_data` <= `mem[rd_addr]` every edge, in every state.
  - `rd_addr` >= `DEPTH` returns 0.
  - A read and a write to the same address on the same edge return the old contents (read-first).
- Storage is not cleared by reset or CLEAR unless the macro is defined. In that default case, stale words read back unchanged.

## Timing
- Reset values:
  - state = CLEAR
  - `in_ready` = 0
  - `load_done` = 0
  - `word_count` = 0
  - `rd_data` = 0
- `in_ready` and `load_done` decode the registered state with no combinational path from `in_valid`.
- If `enable_memory` is sampled 0 at edge t, `in_ready` is 1 during cycle t+1; the earliest transfer is at edge t+2.
- Throughput: one word per cycle. A back-to-back full image takes `DEPTH` cycles of LOAD.
- `load_done` rises in the cycle after the final transfer edge.
- Read latency: 1 cycle, from `rd_addr` at edge t to `rd_data` valid after edge t.
- If `rst` is asserted mid-load, outputs go to their reset values immediately. Loading restarts from address 0 after release.

## Configuration
- `MEM_ZERO_FILL_EN` defined:
  - Every entry into CLEAR (including reset release) starts a sweep writing 0 to addresses 0..`DEPTH`-1, one address per cycle.
  - The sweep runs to completion even if `enable_memory` drops. CLEAR -> LOAD is blocked until the last address is written, so the minimum dwell is `DEPTH` cycles.
  - A new clear (`enable_memory`=1 again) restarts the sweep from 0.
  - Read data during a sweep is undefined.
- `MEM_ZERO_FILL_EN` not defined: CLEAR lasts one cycle and the contents are retained.

## Test plan
- Reset, release, `enable_memory`=0, stream 784 words `k & 8'hFF` back-to-back -> `in_ready` 1 for exactly 784 cycles; `load_done`=1 with `word_count`=784; `rd_addr`=300 gives `rd_data`=8'h2C next cycle.
- Sparse `in_valid` (1 of every 3 cycles), 784 words -> same final contents; `word_count` increments only on transfers.
- At word 400, assert `enable_memory`=1 with `in_valid`=1 -> word discarded, `word_count`=0 next cycle, `in_ready`=0; reload succeeds from address 0.
- `rst`=0 at word 500 -> `in_ready`, `load_done` and `rd_data` go to 0 immediately, without a clock edge; after release, reload completes normally.
- Full buffer, `rd_addr`=800 -> `rd_data`=0; `in_valid` held 1 in FULL -> no `word_count` change.
- With `MEM_ZERO_FILL_EN`: load 784 x 8'hFF, clear, wait 784 cycles -> every address reads 0; `in_ready` stays 0 throughout the sweep even with `enable_memory`=0.
